// File: rtl/param_stack_if.sv
// Operation/observation bundle for the parametrised LIFO stack.
// The controller side drives ops and peek index; the stack side reports contents and status.
interface param_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] write_data;
  logic             err_clr;
  logic [IDX_W-1:0] peek_idx;
  logic [WIDTH-1:0] top_data;
  logic [WIDTH-1:0] next_data;
  logic [WIDTH-1:0] peek_data;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output op_valid, op, write_data, err_clr, peek_idx,
    input  top_data, next_data, peek_data, count, empty, full, overflow, underflow
  );

  modport slave (
    input  op_valid, op, write_data, err_clr, peek_idx,
    output top_data, next_data, peek_data, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/param_stack.sv
// Shift-organised register LIFO: entry 0 is always the top, unoccupied entries hold zero.
// Guarded ops leave state untouched on error and raise sticky overflow/underflow.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic          clock,
  input logic          reset,
  param_stack_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TAB_N = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_REPL  = 3'd3,
    OP_DUP   = 3'd4,
    OP_SWAP  = 3'd5,
    OP_CLEAR = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  logic [WIDTH-1:0] entry     [DEPTH];
  logic [WIDTH-1:0] entry_nxt [DEPTH];
  logic [WIDTH-1:0] peek_tab  [TAB_N];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             overflow_q;
  logic             underflow_q;
  logic             ovf_set;
  logic             unf_set;
  logic             is_empty;
  logic             is_full;
  logic             has_two;
  op_e              op_dec;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);
  assign has_two  = (count_q >= CNT_TWO);
  assign op_dec   = op_e'(bus.op);

  // Next-state decode: every illegal case leaves entry_nxt/count_nxt at their defaults.
  always_comb begin
    entry_nxt = entry;
    count_nxt = count_q;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (bus.op_valid) begin
      case (op_dec)
        OP_PUSH: begin
          if (is_full) begin
            ovf_set = 1'b1;
          end else begin
            for (int i = DEPTH - 1; i > 0; i--) entry_nxt[i] = entry[i-1];
            entry_nxt[0] = bus.write_data;
            count_nxt    = count_q + CNT_ONE;
          end
        end
        OP_POP: begin
          if (is_empty) begin
            unf_set = 1'b1;
          end else begin
            for (int i = 0; i < DEPTH - 1; i++) entry_nxt[i] = entry[i+1];
            entry_nxt[DEPTH-1] = '0;
            count_nxt          = count_q - CNT_ONE;
          end
        end
        OP_REPL: begin
          if (is_empty) unf_set = 1'b1;
          else          entry_nxt[0] = bus.write_data;
        end
        OP_DUP: begin
          if (is_empty) begin
            unf_set = 1'b1;
          end else if (is_full) begin
            ovf_set = 1'b1;
          end else begin
            // Shifting down while entry 0 keeps its value duplicates the top.
            for (int i = DEPTH - 1; i > 0; i--) entry_nxt[i] = entry[i-1];
            count_nxt = count_q + CNT_ONE;
          end
        end
        OP_SWAP: begin
          if (!has_two) begin
            unf_set = 1'b1;
          end else begin
            entry_nxt[0] = entry[1];
            entry_nxt[1] = entry[0];
          end
        end
        OP_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) entry_nxt[i] = '0;
          count_nxt = '0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      entry       <= entry_nxt;
      count_q     <= count_nxt;
      // A fresh error wins over a simultaneous clear request.
      overflow_q  <= ovf_set | (overflow_q  & ~bus.err_clr);
      underflow_q <= unf_set | (underflow_q & ~bus.err_clr);
    end
  end

  // Peek table padded to a power of two so any index value maps to a defined zero.
  for (genvar g = 0; g < TAB_N; g++) begin : g_peek
    if (g < DEPTH) begin : g_live
      assign peek_tab[g] = entry[g];
    end else begin : g_pad
      assign peek_tab[g] = '0;
    end
  end

  assign bus.top_data  = entry[0];
  assign bus.next_data = entry[1];
  assign bus.peek_data = peek_tab[bus.peek_idx];
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: queue-based reference model compared every cycle,
// plus hand-computed literal expectations along the stimulus sequence.
module tb_param_stack;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam logic [2:0] P_NOP = 3'd0, P_PUSH = 3'd1, P_POP = 3'd2, P_REPL = 3'd3,
                         P_DUP = 3'd4, P_SWAP = 3'd5, P_CLEAR = 3'd6, P_RSVD = 3'd7;

  logic clock = 1'b0;
  logic reset;

  param_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: queue index 0 is the top of stack.
  int unsigned mstk[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit ev_ovf, ev_unf;
  int unsigned tmp;

  function automatic logic [31:0] m_at(input int i);
    return (i < mstk.size()) ? mstk[i] : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      mstk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      ev_ovf = 1'b0;
      ev_unf = 1'b0;
      if (bus.op_valid) begin
        case (bus.op)
          P_PUSH:  if (mstk.size() == DEPTH) ev_ovf = 1'b1;
                   else mstk.push_front(int'(bus.write_data));
          P_POP:   if (mstk.size() == 0) ev_unf = 1'b1;
                   else tmp = mstk.pop_front();
          P_REPL:  if (mstk.size() == 0) ev_unf = 1'b1;
                   else mstk[0] = int'(bus.write_data);
          P_DUP:   if (mstk.size() == 0) ev_unf = 1'b1;
                   else if (mstk.size() == DEPTH) ev_ovf = 1'b1;
                   else mstk.push_front(mstk[0]);
          P_SWAP:  if (mstk.size() < 2) ev_unf = 1'b1;
                   else begin tmp = mstk[0]; mstk[0] = mstk[1]; mstk[1] = tmp; end
          P_CLEAR: mstk.delete();
          default: ;
        endcase
      end
      if (bus.err_clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (ev_ovf) m_ovf = 1'b1;
      if (ev_unf) m_unf = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("m_top",   bus.top_data,  m_at(0));
      check("m_next",  bus.next_data, m_at(1));
      check("m_peek",  bus.peek_data, m_at(int'(bus.peek_idx)));
      check("m_count", bus.count,     mstk.size());
      check("m_empty", bus.empty,     mstk.size() == 0);
      check("m_full",  bus.full,      mstk.size() == DEPTH);
      check("m_ovf",   bus.overflow,  m_ovf);
      check("m_unf",   bus.underflow, m_unf);
    end
  end

  // Drive one cycle's inputs, then return just after the following falling edge.
  task automatic step(input logic v, input logic [2:0] o, input logic [7:0] d,
                      input logic ec, input logic [3:0] pi, input logic rs);
    bus.op_valid   = v;
    bus.op         = o;
    bus.write_data = d;
    bus.err_clr    = ec;
    bus.peek_idx   = pi;
    reset          = rs;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [7:0] d, input logic [3:0] pi);
    step(1'b1, o, d, 1'b0, pi, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.op_valid = 1'b0; bus.op = P_NOP; bus.write_data = '0; bus.err_clr = 1'b0; bus.peek_idx = '0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk_en = 1'b1;
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full",  bus.full, 0);
    check("rst_top",   bus.top_data, 0);
    check("rst_flags", {bus.overflow, bus.underflow}, 0);
    step(1'b0, P_NOP, 8'h00, 1'b0, 4'd0, 1'b0);

    do_op(P_PUSH, 8'h11, 4'd2);
    do_op(P_PUSH, 8'h22, 4'd2);
    do_op(P_PUSH, 8'h33, 4'd2);
    check("p3_top",   bus.top_data, 8'h33);
    check("p3_next",  bus.next_data, 8'h22);
    check("p3_peek2", bus.peek_data, 8'h11);
    check("p3_count", bus.count, 3);
    check("p3_empty", bus.empty, 0);

    repeat (3) do_op(P_POP, 8'h00, 4'd0);
    check("pop3_top",   bus.top_data, 0);
    check("pop3_count", bus.count, 0);
    check("pop3_empty", bus.empty, 1);
    check("pop3_unf",   bus.underflow, 0);
    do_op(P_POP, 8'h00, 4'd0);
    check("pop4_unf",   bus.underflow, 1);
    check("pop4_count", bus.count, 0);
    step(1'b0, P_NOP, 8'h00, 1'b1, 4'd0, 1'b0);
    check("clr_unf", bus.underflow, 0);

    for (int i = 0; i < DEPTH; i++) do_op(P_PUSH, 8'(i), 4'd15);
    check("fill_full",  bus.full, 1);
    check("fill_count", bus.count, 16);
    check("fill_peek",  bus.peek_data, 8'h00);
    check("fill_top",   bus.top_data, 8'h0F);
    do_op(P_PUSH, 8'hAA, 4'd15);
    check("ovf_flag", bus.overflow, 1);
    check("ovf_top",  bus.top_data, 8'h0F);
    check("ovf_peek", bus.peek_data, 8'h00);
    do_op(P_DUP, 8'h00, 4'd15);
    check("dupf_ovf",   bus.overflow, 1);
    check("dupf_count", bus.count, 16);
    check("dupf_next",  bus.next_data, 8'h0E);
    for (int i = 0; i < DEPTH; i++) step(1'b0, P_PUSH, 8'h55, 1'b0, 4'(i), 1'b0);

    do_op(P_CLEAR, 8'h00, 4'd0);
    check("clr_ovf_kept", bus.overflow, 1);
    step(1'b0, P_NOP, 8'h00, 1'b1, 4'd0, 1'b0);
    do_op(P_PUSH, 8'h07, 4'd2);
    do_op(P_PUSH, 8'h05, 4'd2);
    do_op(P_SWAP, 8'h00, 4'd2);
    check("swap_top",  bus.top_data, 8'h07);
    check("swap_next", bus.next_data, 8'h05);
    do_op(P_REPL, 8'h99, 4'd2);
    check("repl_top",   bus.top_data, 8'h99);
    check("repl_count", bus.count, 2);
    do_op(P_DUP, 8'h00, 4'd2);
    check("dup_top",   bus.top_data, 8'h99);
    check("dup_next",  bus.next_data, 8'h99);
    check("dup_peek2", bus.peek_data, 8'h05);
    check("dup_count", bus.count, 3);
    do_op(P_RSVD, 8'hEE, 4'd1);
    check("rsvd_count", bus.count, 3);

    do_op(P_CLEAR, 8'h00, 4'd0);
    do_op(P_SWAP, 8'h00, 4'd0);
    check("swap_e_unf", bus.underflow, 1);
    step(1'b0, P_NOP, 8'h00, 1'b1, 4'd0, 1'b0);
    step(1'b1, P_POP, 8'h00, 1'b1, 4'd0, 1'b0);
    check("setwin_unf", bus.underflow, 1);
    do_op(P_REPL, 8'h44, 4'd0);
    do_op(P_PUSH, 8'hA1, 4'd0);
    do_op(P_SWAP, 8'h00, 4'd1);
    check("swap1_next", bus.next_data, 8'h00);
    do_op(P_PUSH, 8'hA2, 4'd0);
    do_op(P_PUSH, 8'hA3, 4'd0);
    do_op(P_CLEAR, 8'h00, 4'd0);
    check("clr3_count", bus.count, 0);
    check("clr3_top",   bus.top_data, 0);
    check("clr3_unf",   bus.underflow, 1);
    check("clr3_ovf",   bus.overflow, 0);

    for (int i = 0; i < 5; i++) do_op(P_PUSH, 8'(8'h60 + i), 4'd4);
    do_op(P_POP, 8'h00, 4'd4);
    check("pop_zero_fill", bus.peek_data, 8'h00);
    do_op(P_PUSH, 8'h64, 4'd4);
    step(1'b1, P_PUSH, 8'h77, 1'b0, 4'd0, 1'b1);
    check("mrst_count", bus.count, 0);
    check("mrst_top",   bus.top_data, 0);
    check("mrst_flags", {bus.overflow, bus.underflow}, 0);
    step(1'b0, P_NOP, 8'h00, 1'b0, 4'd0, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
